// File: rtl/truth_table_sweeper.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Purpose
//   Exhaustively drives all sixteen 4-bit vectors into a 4-input, 1-output
//   combinational cone, captures the cone's response for each vector into a
//   16-bit truth table, and compares that table against EXPECTED. Reports
//   overall pass/fail, the lowest failing minterm and the number of failing
//   minterms. Intended for on-chip equivalence checks of gate netlists.
//
// Parameters
//   EXPECTED   expected truth table; bit i is the response for stim == i
//   SETTLE     cycles stim is held stable before resp is sampled (1..255)
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active-high, dominates all inputs
//   start      in   1   pulse to begin a sweep
//   stim       out  4   vector driven into the cone (stim[n] -> cone input n)
//   resp       in   1   cone output, combinational in stim
//   busy       out  1   high from the cycle after start is accepted until done
//   done       out  1   one-cycle pulse when a sweep completes
//   table_q    out  16  captured truth table, held until the next sweep starts
//   pass       out  1   table_q == EXPECTED, valid from done until next start
//   first_bad  out  4   lowest mismatching minterm index, 0 when passing
//   bad_cnt    out  5   number of mismatching minterms (0..16)
//   state_dbg  out  2   current FSM state, for observation only
//
// Handshake
//   start is a request that is accepted only on a cycle where the sweeper is
//   idle: busy=0 and done=0. Requests on any other cycle (mid-sweep, in the
//   finishing cycle, or while done is high) are dropped, not queued. busy is
//   the "not ready" indication; done marks completion and result validity.
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter logic [15:0] EXPECTED = 16'h1CBF,
    parameter int unsigned SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  stim,
    input  logic        resp,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_q,
    output logic        pass,
    output logic [3:0]  first_bad,
    output logic [4:0]  bad_cnt,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    // The counter counts SETTLE-1 down to 0, so SETTLE cycles are spent in
    // S_SETTLE per vector; the following S_SAMPLE cycle captures resp.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    state_t     state;
    logic [3:0] idx;
    logic [7:0] settle_cnt;
    logic       accept;
    logic       mismatch;

    // done is still high in the cycle after S_FINISH (state already S_IDLE);
    // gating on it keeps a start in the done cycle from launching a sweep.
    always_comb begin
        accept   = 1'b0;
        accept   = start && (state == S_IDLE) && !done;
        mismatch = 1'b0;
        mismatch = (resp != EXPECTED[idx]);
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= 4'd0;
            settle_cnt <= 8'd0;
            stim       <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_q    <= 16'd0;
            pass       <= 1'b0;
            first_bad  <= 4'd0;
            bad_cnt    <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        stim       <= 4'd0;
                        idx        <= 4'd0;
                        settle_cnt <= SETTLE_LOAD;
                        table_q    <= 16'd0;
                        bad_cnt    <= 5'd0;
                        pass       <= 1'b0;
                        first_bad  <= 4'd0;
                        busy       <= 1'b1;
                        state      <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end

                S_SAMPLE: begin
                    table_q[idx] <= resp;
                    if (mismatch) begin
                        bad_cnt <= bad_cnt + 5'd1;
                        // bad_cnt still zero means this is the first mismatch
                        if (bad_cnt == 5'd0) begin
                            first_bad <= idx;
                        end
                    end
                    if (idx == 4'd15) begin
                        // stim deliberately stays at 15 after the sweep
                        state <= S_FINISH;
                    end else begin
                        idx        <= idx + 4'd1;
                        stim       <= idx + 4'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_SETTLE;
                    end
                end

                S_FINISH: begin
                    // bad_cnt already includes the last (idx 15) sample here
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (bad_cnt == 5'd0);
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
`timescale 1ns/1ps
// Bench for truth_table_sweeper. Five instances share clk/rst/start:
//   0: resp = ^stim,  EXPECTED 6996, SETTLE 2
//   1: resp = ^stim,  EXPECTED 6997, SETTLE 2
//   2: resp = 0,      EXPECTED FFFF, SETTLE 2
//   3: resp = &stim,  EXPECTED 8000, SETTLE 1
//   4: resp = lut[stim] (random table), EXPECTED 1CBF, SETTLE 2
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] lut;

  logic [3:0]  stim_w [5];
  logic        resp_w [5];
  logic        busy_w [5];
  logic        done_w [5];
  logic [15:0] tq_w   [5];
  logic        pass_w [5];
  logic [3:0]  fb_w   [5];
  logic [4:0]  bc_w   [5];
  logic [1:0]  sd_w   [5];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int dcount [5];
  int dcyc   [5];
  logic [3:0] slog0 [$];
  logic [3:0] slog3 [$];
  logic [3:0] exp_q [$];

  typedef struct {
    int          k;
    logic [15:0] tbl;
    logic        p;
    logic [4:0]  nbad;
    logic [3:0]  fbad;
    int          lat;
  } vec_t;
  vec_t vecs [4];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  assign resp_w[0] = ^stim_w[0];
  assign resp_w[1] = ^stim_w[1];
  assign resp_w[2] = 1'b0;
  assign resp_w[3] = &stim_w[3];
  assign resp_w[4] = lut[stim_w[4]];

  truth_table_sweeper #(.EXPECTED(16'h6996), .SETTLE(2)) u_xor (
    .clk(clk), .rst(rst), .start(start), .stim(stim_w[0]), .resp(resp_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .table_q(tq_w[0]), .pass(pass_w[0]),
    .first_bad(fb_w[0]), .bad_cnt(bc_w[0]), .state_dbg(sd_w[0]));

  truth_table_sweeper #(.EXPECTED(16'h6997), .SETTLE(2)) u_xor_bad (
    .clk(clk), .rst(rst), .start(start), .stim(stim_w[1]), .resp(resp_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .table_q(tq_w[1]), .pass(pass_w[1]),
    .first_bad(fb_w[1]), .bad_cnt(bc_w[1]), .state_dbg(sd_w[1]));

  truth_table_sweeper #(.EXPECTED(16'hFFFF), .SETTLE(2)) u_zero (
    .clk(clk), .rst(rst), .start(start), .stim(stim_w[2]), .resp(resp_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .table_q(tq_w[2]), .pass(pass_w[2]),
    .first_bad(fb_w[2]), .bad_cnt(bc_w[2]), .state_dbg(sd_w[2]));

  truth_table_sweeper #(.EXPECTED(16'h8000), .SETTLE(1)) u_and (
    .clk(clk), .rst(rst), .start(start), .stim(stim_w[3]), .resp(resp_w[3]),
    .busy(busy_w[3]), .done(done_w[3]), .table_q(tq_w[3]), .pass(pass_w[3]),
    .first_bad(fb_w[3]), .bad_cnt(bc_w[3]), .state_dbg(sd_w[3]));

  truth_table_sweeper u_rand (
    .clk(clk), .rst(rst), .start(start), .stim(stim_w[4]), .resp(resp_w[4]),
    .busy(busy_w[4]), .done(done_w[4]), .table_q(tq_w[4]), .pass(pass_w[4]),
    .first_bad(fb_w[4]), .bad_cnt(bc_w[4]), .state_dbg(sd_w[4]));

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (done_w[k]) begin
        dcount[k] = dcount[k] + 1;
        dcyc[k]   = cyc;
      end
    end
    if (busy_w[0]) slog0.push_back(stim_w[0]);
    if (busy_w[3]) slog3.push_back(stim_w[3]);
  end

  // ---------------- scoreboard helpers ----------------
  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  function automatic void timeout_fail(string name);
    total++;
    bad++;
    $display("FAIL %s: no done within cycle budget", name);
  endfunction

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  // Expected stim trace while busy: each vector held hold_cycles, then one
  // finishing cycle that still shows 15.
  task automatic check_stim_trace(string name, int k, int base, int hold_cycles);
    int n;
    exp_q.delete();
    for (int v = 0; v < 16; v++)
      for (int h = 0; h < hold_cycles; h++) exp_q.push_back(4'(v));
    exp_q.push_back(4'd15);
    n = (k == 0) ? slog0.size() - base : slog3.size() - base;
    check({name, "_len"}, 32'(n), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < n; j++) begin
      if (k == 0) check(name, 32'(slog0[base + j]), 32'(exp_q[j]));
      else        check(name, 32'(slog3[base + j]), 32'(exp_q[j]));
    end
  endtask

  task automatic run_vectors(string tag);
    int  base [4];
    int  b0, b3;
    bit  ok;
    for (int k = 0; k < 4; k++) base[k] = dcount[k];
    b0 = slog0.size();
    b3 = slog3.size();
    pulse_start();
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk);
      #2;
      ok = (dcount[0] > base[0]) && (dcount[1] > base[1]) &&
           (dcount[2] > base[2]) && (dcount[3] > base[3]);
    end
    if (!ok) timeout_fail({tag, "_timeout"});
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = vecs[i].k;
      check($sformatf("%s_table%0d", tag, k), 32'(tq_w[k]), 32'(vecs[i].tbl));
      check($sformatf("%s_pass%0d", tag, k), 32'(pass_w[k]), 32'(vecs[i].p));
      check($sformatf("%s_badcnt%0d", tag, k), 32'(bc_w[k]), 32'(vecs[i].nbad));
      check($sformatf("%s_firstbad%0d", tag, k), 32'(fb_w[k]), 32'(vecs[i].fbad));
      check($sformatf("%s_latency%0d", tag, k), 32'(dcyc[k] - t0), 32'(vecs[i].lat));
      check($sformatf("%s_donecount%0d", tag, k), 32'(dcount[k] - base[k]), 32'd1);
      check($sformatf("%s_busy_after%0d", tag, k), 32'(busy_w[k]), 32'd0);
      check($sformatf("%s_stim_hold%0d", tag, k), 32'(stim_w[k]), 32'd15);
    end
    check_stim_trace({tag, "_stim0"}, 0, b0, 3);
    check_stim_trace({tag, "_stim3"}, 3, b3, 2);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{0, 16'h6996, 1'b1, 5'd0,  4'd0, 49};
    vecs[1] = '{1, 16'h6996, 1'b0, 5'd1,  4'd0, 49};
    vecs[2] = '{2, 16'h0000, 1'b0, 5'd16, 4'd0, 49};
    vecs[3] = '{3, 16'h8000, 1'b1, 5'd0,  4'd0, 33};

    rst   = 1'b1;
    start = 1'b0;
    lut   = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rst_stim%0d", k), 32'(stim_w[k]), 32'd0);
      check($sformatf("rst_busy%0d", k), 32'(busy_w[k]), 32'd0);
      check($sformatf("rst_done%0d", k), 32'(done_w[k]), 32'd0);
      check($sformatf("rst_table%0d", k), 32'(tq_w[k]), 32'd0);
      check($sformatf("rst_pass%0d", k), 32'(pass_w[k]), 32'd0);
      check($sformatf("rst_firstbad%0d", k), 32'(fb_w[k]), 32'd0);
      check($sformatf("rst_badcnt%0d", k), 32'(bc_w[k]), 32'd0);
    end
    rst = 1'b0;

    run_vectors("v1");

    // reset on cycle 20 of a sweep aborts it without a done pulse
    begin
      int base [4];
      pulse_start();
      repeat (19) @(posedge clk);
      @(negedge clk);
      check("midsweep_busy_before", 32'(busy_w[0]), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("abort_busy%0d", k), 32'(busy_w[k]), 32'd0);
        check($sformatf("abort_stim%0d", k), 32'(stim_w[k]), 32'd0);
        check($sformatf("abort_table%0d", k), 32'(tq_w[k]), 32'd0);
        check($sformatf("abort_badcnt%0d", k), 32'(bc_w[k]), 32'd0);
        check($sformatf("abort_done%0d", k), 32'(done_w[k]), 32'd0);
        base[k] = dcount[k];
      end
      rst = 1'b0;
      repeat (80) @(posedge clk);
      #2;
      for (int k = 0; k < 4; k++)
        check($sformatf("abort_nodone%0d", k), 32'(dcount[k] - base[k]), 32'd0);
    end

    run_vectors("v2");

    // start re-pulsed while busy and in the done cycle: one sweep only
    begin
      int  base0;
      bit  seen;
      base0 = dcount[0];
      pulse_start();
      repeat (9) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
        @(posedge clk);
        #2;
        seen = done_w[0];
      end
      if (!seen) timeout_fail("repulse_timeout");
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (120) @(posedge clk);
      @(negedge clk);
      check("repulse_donecount", 32'(dcount[0] - base0), 32'd1);
      check("repulse_latency", 32'(dcyc[0] - t0), 32'd49);
      check("repulse_busy", 32'(busy_w[0]), 32'd0);
      check("repulse_table", 32'(tq_w[0]), 32'h6996);
      check("repulse_pass", 32'(pass_w[0]), 32'd1);
    end
    repeat (40) @(posedge clk);

    // random cone functions against a reference of the comparison rules
    for (int it = 0; it < 20; it++) begin
      int          base4;
      int          mode;
      bit          fin;
      logic [15:0] diff;
      int          exp_bad;
      int          exp_first;
      mode = $urandom_range(0, 3);
      if (mode == 0)      lut = 16'h1CBF;
      else if (mode == 1) lut = 16'h1CBF ^ (16'h1 << $urandom_range(0, 15));
      else                lut = 16'($urandom);
      diff      = lut ^ 16'h1CBF;
      exp_bad   = 0;
      exp_first = -1;
      for (int i = 0; i < 16; i++) begin
        if (diff[i]) begin
          exp_bad++;
          if (exp_first < 0) exp_first = i;
        end
      end
      if (exp_first < 0) exp_first = 0;

      base4 = dcount[4];
      pulse_start();
      fin = 1'b0;
      for (int n = 0; n < 200 && !fin; n++) begin
        @(negedge clk);
        #1;
        fin = (dcount[4] > base4);
        if (!fin) start = busy_w[4] && ($urandom_range(0, 4) == 0);
      end
      start = 1'b0;
      if (!fin) timeout_fail($sformatf("rand%0d_timeout", it));
      check($sformatf("rand%0d_table", it), 32'(tq_w[4]), 32'(lut));
      check($sformatf("rand%0d_pass", it), 32'(pass_w[4]), 32'(exp_bad == 0));
      check($sformatf("rand%0d_badcnt", it), 32'(bc_w[4]), 32'(exp_bad));
      check($sformatf("rand%0d_firstbad", it), 32'(fb_w[4]), 32'(exp_first));
      check($sformatf("rand%0d_latency", it), 32'(dcyc[4] - t0), 32'd49);
    end
    repeat (60) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
